kv_cmd_master: RTL

Command-side bus master that sits directly upstream of the key/value store and is its only bus initiator. It accepts INSERT / UPDATE / READ commands over a valid/ready interface and sequences the store's STB/CYC/WE/STALL/ACK handshake. It returns one response per command, carrying read data, the assigned slot index or an error code. A timeout watchdog recovers a hung transaction by pulsing the store's RESET input.

---
 rtl/kv_pkg.sv | 46 ++++
 rtl/kv_cmd_master_if.sv | 43 ++++
 rtl/kv_cmd_master.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/kv_pkg.sv
// Shared encodings, command payload and small helpers for the key/value command master.
package kv_pkg;

    localparam int unsigned KV_W     = 16;
    localparam int unsigned KV_TMO_W = 8;

    typedef enum logic [1:0] {
        KV_OP_INSERT = 2'd0,
        KV_OP_UPDATE = 2'd1,
        KV_OP_READ   = 2'd2,
        KV_OP_RSVD   = 2'd3
    } kv_op_e;

    typedef enum logic [1:0] {
        KV_ERR_OK       = 2'd0,
        KV_ERR_OVERFLOW = 2'd1,
        KV_ERR_TIMEOUT  = 2'd2,
        KV_ERR_BADCMD   = 2'd3
    } kv_err_e;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_STALL,
        WAIT_ACK,
        RSP
    } kv_state_e;

    typedef struct packed {
        kv_op_e          op;
        logic [KV_W-1:0] addr;
        logic [KV_W-1:0] key;
        logic [KV_W-1:0] data;
    } kv_cmd_t;

    // Watchdog counter increment that sticks at all-ones.
    function automatic logic [KV_TMO_W-1:0] kv_sat_inc(input logic [KV_TMO_W-1:0] v);
        return (&v) ? v : v + KV_TMO_W'(1);
    endfunction

    // Reserved op, or a slot-addressed op aimed at slot 0, never reaches the store.
    function automatic logic kv_cmd_bad(input kv_cmd_t c);
        return (c.op == KV_OP_RSVD) || ((c.op != KV_OP_INSERT) && (c.addr == '0));
    endfunction

endpackage

// File: rtl/kv_cmd_master_if.sv
// Command/response channel plus the store-side bus of the key/value command master.
interface kv_cmd_master_if;

    localparam int unsigned W = kv_pkg::KV_W;

    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [W-1:0] cmd_addr;
    logic [W-1:0] cmd_key;
    logic [W-1:0] cmd_data;

    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_data;
    logic [1:0]   rsp_err;

    logic [W-1:0] ADR_o;
    logic [W-1:0] DAT_o;
    logic [W-1:0] KEY_o;
    logic         WE_o;
    logic         STB_o;
    logic         CYC_o;
    logic         RESET_o;
    logic         STALL_i;
    logic         ACK_i;
    logic [W-1:0] DAT_i;

    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_key, cmd_data, rsp_ready,
        input  STALL_i, ACK_i, DAT_i,
        output cmd_ready, rsp_valid, rsp_data, rsp_err,
        output ADR_o, DAT_o, KEY_o, WE_o, STB_o, CYC_o, RESET_o
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_key, cmd_data, rsp_ready,
        output STALL_i, ACK_i, DAT_i,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err,
        input  ADR_o, DAT_o, KEY_o, WE_o, STB_o, CYC_o, RESET_o
    );

endinterface

// File: rtl/kv_cmd_master.sv
// Sole bus initiator for the key/value store: one command in flight, one response out,
// with a watchdog that pulses the store reset when a transaction hangs.
module kv_cmd_master
    import kv_pkg::*;
#(
    parameter int unsigned SLOTS   = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    kv_cmd_master_if.master bus
);

    localparam logic [KV_TMO_W-1:0] TMO_LAST = KV_TMO_W'(TIMEOUT - 1);
    localparam logic [KV_W-1:0]     SLOTS_W  = KV_W'(SLOTS);

    kv_state_e           state;
    kv_op_e              op_q;
    logic [KV_TMO_W-1:0] tmo_cnt;

    kv_cmd_t cmd_c;
    logic    bad_c;
    logic    tmo_hit_c;

    assign cmd_c = '{op:   kv_op_e'(bus.cmd_op),
                     addr: bus.cmd_addr,
                     key:  bus.cmd_key,
                     data: bus.cmd_data};
    assign bad_c     = kv_cmd_bad(cmd_c);
    assign tmo_hit_c = (tmo_cnt >= TMO_LAST);

    // Single registered FSM; every output is a flop updated alongside the state.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state         <= IDLE;
            op_q          <= KV_OP_INSERT;
            tmo_cnt       <= '0;
            bus.cmd_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            bus.rsp_err   <= KV_ERR_OK;
            bus.ADR_o     <= '0;
            bus.DAT_o     <= '0;
            bus.KEY_o     <= '0;
            bus.WE_o      <= 1'b0;
            bus.STB_o     <= 1'b0;
            bus.CYC_o     <= 1'b0;
            bus.RESET_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        bus.cmd_ready <= 1'b0;
                        op_q          <= cmd_c.op;
                        tmo_cnt       <= '0;
                        if (bad_c) begin
                            state         <= RSP;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_data  <= '0;
                            bus.rsp_err   <= KV_ERR_BADCMD;
                        end else begin
                            state     <= REQ;
                            bus.STB_o <= 1'b1;
                            bus.CYC_o <= 1'b1;
                            bus.WE_o  <= (cmd_c.op != KV_OP_READ);
                            bus.ADR_o <= (cmd_c.op == KV_OP_INSERT) ? '0 : cmd_c.addr;
                            bus.DAT_o <= cmd_c.data;
                            bus.KEY_o <= cmd_c.key;
                        end
                    end
                end

                // Reads keep the cycle open to collect data; writes close it and just await ACK.
                REQ: begin
                    bus.STB_o <= 1'b0;
                    if (op_q == KV_OP_READ) begin
                        state <= WAIT_STALL;
                    end else begin
                        state     <= WAIT_ACK;
                        bus.CYC_o <= 1'b0;
                        bus.WE_o  <= 1'b0;
                    end
                end

                // The store's STALL is still stale on the first cycle here (tmo_cnt == 0).
                WAIT_STALL: begin
                    if (bus.RESET_o) begin
                        bus.RESET_o   <= 1'b0;
                        state         <= RSP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_data  <= '0;
                        bus.rsp_err   <= KV_ERR_TIMEOUT;
                    end else if ((tmo_cnt != '0) && !bus.STALL_i) begin
                        state        <= WAIT_ACK;
                        bus.rsp_data <= bus.DAT_i;
                        bus.CYC_o    <= 1'b0;
                        tmo_cnt      <= kv_sat_inc(tmo_cnt);
                    end else if (tmo_hit_c) begin
                        bus.RESET_o <= 1'b1;
                        bus.STB_o   <= 1'b0;
                        bus.CYC_o   <= 1'b0;
                        bus.WE_o    <= 1'b0;
                    end else begin
                        tmo_cnt <= kv_sat_inc(tmo_cnt);
                    end
                end

                WAIT_ACK: begin
                    if (bus.RESET_o) begin
                        bus.RESET_o   <= 1'b0;
                        state         <= RSP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_data  <= '0;
                        bus.rsp_err   <= KV_ERR_TIMEOUT;
                    end else if (bus.ACK_i) begin
                        state         <= RSP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= KV_ERR_OK;
                        // Read data was already captured when STALL dropped.
                        if (op_q != KV_OP_READ) begin
                            bus.rsp_data <= bus.DAT_i;
                            if ((op_q == KV_OP_INSERT) && (bus.DAT_i >= SLOTS_W)) begin
                                bus.rsp_err <= KV_ERR_OVERFLOW;
                            end
                        end
                    end else if (tmo_hit_c) begin
                        bus.RESET_o <= 1'b1;
                        bus.STB_o   <= 1'b0;
                        bus.CYC_o   <= 1'b0;
                        bus.WE_o    <= 1'b0;
                    end else begin
                        tmo_cnt <= kv_sat_inc(tmo_cnt);
                    end
                end

                RSP: begin
                    if (bus.rsp_ready) begin
                        state         <= IDLE;
                        bus.rsp_valid <= 1'b0;
                        bus.cmd_ready <= 1'b1;
                    end
                end

                default: begin
                    state         <= IDLE;
                    bus.cmd_ready <= 1'b1;
                    bus.rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
